// File: rtl/dftn_pkg.sv
// Shared types and rotation helpers for the trivial-twiddle streaming DFT.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package dftn_pkg;

    typedef enum logic {ACCUM, DRAIN} state_t;

    // Rotation codes: multiply by +1, -j, -1, +j respectively.
    localparam logic [1:0] ROT_P1 = 2'd0;
    localparam logic [1:0] ROT_MJ = 2'd1;
    localparam logic [1:0] ROT_M1 = 2'd2;
    localparam logic [1:0] ROT_PJ = 2'd3;

    // Twiddle W_N^(n*k) expressed as a rotation code. For N=2 the only
    // non-trivial twiddle is -1, so an odd product maps to ROT_M1.
    function automatic logic [1:0] rot_idx(input int n, input int k, input int npts);
        if (npts == 2) begin
            return (((n * k) % 2) != 0) ? ROT_M1 : ROT_P1;
        end
        return 2'((n * k) % 4);
    endfunction

endpackage

// File: rtl/dftn_stream_if.sv
// Sample-in and bin-out handshake bundle for dftn_stream.
// Latency: n/a (wiring only).
// Backpressure: carries in_ready toward the source and out_ready from the consumer.
interface dftn_stream_if #(
    parameter int W = 16,
    parameter int N = 4
);
    localparam int OW = W + $clog2(N);
    localparam int BW = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_re;
    logic signed [W-1:0]  in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
    logic [BW-1:0]        out_bin;
    logic                 out_last;

    // Source/consumer side.
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_bin, out_last
    );

    // DFT engine side.
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_bin, out_last
    );
endinterface

// File: rtl/cplx_rot.sv
// Rotates a complex value by +1, -j, -1 or +j using only negation and swap.
// Latency: combinational.
// Backpressure: none.
module cplx_rot
    import dftn_pkg::*;
#(
    parameter int OW = 18
) (
    input  logic [1:0]           r,
    input  logic signed [OW-1:0] re,
    input  logic signed [OW-1:0] im,
    output logic signed [OW-1:0] re_o,
    output logic signed [OW-1:0] im_o
);

    // Select the swapped/negated component pair for the requested rotation.
    always_comb begin
        re_o = re;
        im_o = im;
        case (r)
            ROT_MJ: begin re_o = im;  im_o = -re; end
            ROT_M1: begin re_o = -re; im_o = -im; end
            ROT_PJ: begin re_o = -im; im_o = re;  end
            default: begin re_o = re; im_o = im; end
        endcase
    end

endmodule

// File: rtl/dftn_stream.sv
// Streaming N-point DFT (N=2 or 4): accumulates all bins per frame, then drains them in order.
// Latency: bin 0 valid the cycle after the last sample of a frame is accepted.
// Backpressure: input stalls (in_ready=0) for the whole drain; each bin held until out_ready.
module dftn_stream
    import dftn_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    dftn_stream_if.slave s
);

    localparam int OW = W + $clog2(N);
    localparam int BW = $clog2(N);
    localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);

    generate
        if (N != 2 && N != 4) begin : g_bad_n
            $error("dftn_stream: N must be 2 or 4");
        end
    endgenerate

    state_t               state;
    state_t               state_nxt;
    logic                 acc_phase;
    logic                 drain_phase;
    logic                 accept;
    logic                 bin_hs;
    logic [BW-1:0]        cnt;
    logic [BW-1:0]        bin;
    logic signed [OW-1:0] x_re;
    logic signed [OW-1:0] x_im;
    logic signed [OW-1:0] rot_re [N];
    logic signed [OW-1:0] rot_im [N];
    logic signed [OW-1:0] sum_re [N];
    logic signed [OW-1:0] sum_im [N];
    logic signed [OW-1:0] acc_re [N];
    logic signed [OW-1:0] acc_im [N];
    logic signed [OW-1:0] bin_re [N];
    logic signed [OW-1:0] bin_im [N];

    // Sign-extend before rotation so negating the most negative input cannot wrap.
    assign x_re = {{(OW-W){s.in_re[W-1]}}, s.in_re};
    assign x_im = {{(OW-W){s.in_im[W-1]}}, s.in_im};

    assign accept = acc_phase && s.in_valid;
    assign bin_hs = drain_phase && s.out_ready;

    // One rotator per bin; the first sample of a frame loads rather than adds.
    generate
        for (genvar k = 0; k < N; k++) begin : g_bin
            logic [1:0] r;
            assign r = rot_idx(int'(cnt), k, N);
            cplx_rot #(.OW(OW)) u_rot (
                .r    (r),
                .re   (x_re),
                .im   (x_im),
                .re_o (rot_re[k]),
                .im_o (rot_im[k])
            );
            assign sum_re[k] = (cnt == '0) ? rot_re[k] : acc_re[k] + rot_re[k];
            assign sum_im[k] = (cnt == '0) ? rot_im[k] : acc_im[k] + rot_im[k];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Next state and phase decodes; ready/valid depend on state only.
    always_comb begin
        state_nxt   = state;
        acc_phase   = 1'b0;
        drain_phase = 1'b0;
        case (state)
            ACCUM: begin
                acc_phase = 1'b1;
                if (s.in_valid && cnt == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: begin
                drain_phase = 1'b1;
                if (s.out_ready && bin == LAST_IDX) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Sample counter and drain index; both wrap naturally since N is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            bin <= '0;
        end else begin
            if (accept) cnt <= cnt + 1'b1;
            if (bin_hs) bin <= bin + 1'b1;
        end
    end

    // Running sums, snapshotted into the bin registers on the frame's last sample.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (accept) begin
                acc_re[k] <= sum_re[k];
                acc_im[k] <= sum_im[k];
            end
            if (accept && cnt == LAST_IDX) begin
                bin_re[k] <= sum_re[k];
                bin_im[k] <= sum_im[k];
            end
        end
    end

    assign s.in_ready  = acc_phase;
    assign s.out_valid = drain_phase;
    assign s.out_bin   = bin;
    assign s.out_last  = drain_phase && (bin == LAST_IDX);
    assign s.out_re    = drain_phase ? bin_re[bin] : '0;
    assign s.out_im    = drain_phase ? bin_im[bin] : '0;

endmodule
